uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `UART_driver` transmitter between `NUM_REQ` independent requesters. It accepts one word per handshake from each requester and drives the driver's start/data inputs. It tracks the driver's busy signal through each frame, supports short bursts per grant, and flags a driver that never acknowledges a start or reports a frame error. It sits between the command/status sources and the single UART instance.

---
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares a single UART transmitter between NUM_REQ requesters,
// with short per-grant bursts, a start-acknowledge timeout and sticky error flags.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 9,
  parameter int ACK_TIMEOUT = 64,
  parameter int MAX_BURST   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       uart_start,
  output logic [DATA_W-1:0]          uart_data,
  input  logic                       uart_busy,
  input  logic                       uart_error,
  input  logic                       err_clr,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       timeout_err,
  output logic                       frame_err
);

  localparam int GW  = $clog2(NUM_REQ);
  localparam int GW1 = GW + 1;
  localparam int CW  = $clog2(ACK_TIMEOUT + 1);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [GW1-1:0] NUM_REQ_W  = GW1'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_req_ack;
  logic                r_uart_start;
  logic [DATA_W-1:0]   r_uart_data;
  logic [GW-1:0]       r_grant;
  logic [GW-1:0]       r_last_grant;
  logic [BW-1:0]       r_burst_cnt;
  logic [CW-1:0]       r_to_cnt;
  logic                r_timeout_err;
  logic                r_frame_err;

  state_t              w_state_nxt;
  logic [NUM_REQ-1:0]  w_ack_nxt;
  logic                w_start_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [GW-1:0]       w_grant_nxt;
  logic [GW-1:0]       w_last_nxt;
  logic [BW-1:0]       w_burst_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_timeout_set;
  logic                w_frame_set;
  logic                w_found;
  logic [GW-1:0]       w_winner;
  logic [GW1-1:0]      w_cand;

  // Search starts one past the last grant and wraps, so the first hit is the round-robin winner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_grant;
    w_cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = {1'b0, r_last_grant} + GW1'(i);
      if (w_cand >= NUM_REQ_W) w_cand = w_cand - NUM_REQ_W;
      if (!w_found && req_valid[w_cand[GW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[GW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ack_nxt     = '0;
    w_start_nxt   = 1'b0;
    w_data_nxt    = r_uart_data;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last_grant;
    w_burst_nxt   = r_burst_cnt;
    w_cnt_nxt     = r_to_cnt;
    w_timeout_set = 1'b0;
    w_frame_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found && !uart_busy) begin
          w_data_nxt           = req_data[w_winner*DATA_W +: DATA_W];
          w_ack_nxt[w_winner]  = 1'b1;
          w_grant_nxt          = w_winner;
          w_burst_nxt          = '0;
          w_state_nxt          = START;
        end
      end
      START: begin
        w_start_nxt = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_busy) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_to_cnt == CNT_LAST) begin
          w_timeout_set = 1'b1;
          w_last_nxt    = r_grant;
          w_state_nxt   = IDLE;
        end else begin
          w_cnt_nxt = r_to_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        w_frame_set = uart_error;
        if (!uart_busy) begin
          // Same requester keeps the driver while it has data and burst budget left.
          if (req_valid[r_grant] && (r_burst_cnt < BURST_LAST)) begin
            w_data_nxt          = req_data[r_grant*DATA_W +: DATA_W];
            w_ack_nxt[r_grant]  = 1'b1;
            w_burst_nxt         = r_burst_cnt + 1'b1;
            w_state_nxt         = START;
          end else begin
            w_last_nxt  = r_grant;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_req_ack     <= '0;
      r_uart_start  <= 1'b0;
      r_uart_data   <= '0;
      r_grant       <= '0;
      r_last_grant  <= GW'(NUM_REQ - 1);
      r_burst_cnt   <= '0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_req_ack     <= w_ack_nxt;
      r_uart_start  <= w_start_nxt;
      r_uart_data   <= w_data_nxt;
      r_grant       <= w_grant_nxt;
      r_last_grant  <= w_last_nxt;
      r_burst_cnt   <= w_burst_nxt;
      r_to_cnt      <= w_cnt_nxt;
      r_timeout_err <= w_timeout_set | (r_timeout_err & ~err_clr);
      r_frame_err   <= w_frame_set | (r_frame_err & ~err_clr);
    end
  end

  assign req_ack     = r_req_ack;
  assign uart_start  = r_uart_start;
  assign uart_data   = r_uart_data;
  assign grant_id    = r_grant;
  assign active      = (r_state != IDLE);
  assign timeout_err = r_timeout_err;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with bursts of 4 and one with bursts of 1,
// each fed by a small UART driver model that holds busy for a programmable number of cycles.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 9;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [NR-1:0]    reqValidA, reqAckA;
  logic [NR*DW-1:0] reqDataA;
  logic             startA, errorA, errClrA, activeA, toErrA, frErrA;
  logic             busyA = 1'b0;
  logic [DW-1:0]    dataA;
  logic [1:0]       grantA;

  logic [NR-1:0]    reqValidB, reqAckB;
  logic [NR*DW-1:0] reqDataB;
  logic             startB, errorB, errClrB, activeB, toErrB, frErrB;
  logic             busyB = 1'b0;
  logic [DW-1:0]    dataB;
  logic [1:0]       grantB;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ACK_TIMEOUT(TO), .MAX_BURST(4)) dutA (
    .clk(clk), .rst(rst), .req_valid(reqValidA), .req_data(reqDataA), .req_ack(reqAckA),
    .uart_start(startA), .uart_data(dataA), .uart_busy(busyA), .uart_error(errorA),
    .err_clr(errClrA), .grant_id(grantA), .active(activeA), .timeout_err(toErrA),
    .frame_err(frErrA)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ACK_TIMEOUT(TO), .MAX_BURST(1)) dutB (
    .clk(clk), .rst(rst), .req_valid(reqValidB), .req_data(reqDataB), .req_ack(reqAckB),
    .uart_start(startB), .uart_data(dataB), .uart_busy(busyB), .uart_error(errorB),
    .err_clr(errClrB), .grant_id(grantB), .active(activeB), .timeout_err(toErrB),
    .frame_err(frErrB)
  );

  // Driver models: busy rises in the cycle start is seen and stays high for busyLen cycles
  int   busyLenA = 20, busyLenB = 4, cntA = 0, cntB = 0;
  logic deadA = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      cntA  = 0;
      busyA = 1'b0;
    end else if (startA && !deadA) begin
      cntA  = busyLenA;
      busyA = 1'b1;
    end else if (cntA > 0) begin
      cntA  = cntA - 1;
      busyA = (cntA > 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      cntB  = 0;
      busyB = 1'b0;
    end else if (startB) begin
      cntB  = busyLenB;
      busyB = 1'b1;
    end else if (cntB > 0) begin
      cntB  = cntB - 1;
      busyB = (cntB > 0);
    end
  end

  int totalChecks = 0;
  int badChecks   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  int            n, t, lastT, nAck, g, seen;
  logic [DW-1:0] word;
  logic [DW-1:0] wordsB [NR];

  initial begin
    rst = 1'b1;
    reqValidA = '0; reqDataA = '0; errorA = 1'b0; errClrA = 1'b0;
    reqValidB = '0; reqDataB = '0; errorB = 1'b0; errClrB = 1'b0;
    repeat (3) applyStimulus();

    // Reset state
    checkOutput("rst_ack", reqAckA, 0);
    checkOutput("rst_start", startA, 0);
    checkOutput("rst_data", dataA, 0);
    checkOutput("rst_grant", grantA, 0);
    checkOutput("rst_active", activeA, 0);
    checkOutput("rst_toerr", toErrA, 0);
    checkOutput("rst_frerr", frErrA, 0);
    rst = 1'b0;

    // Single request: ack one cycle after sampling, start one cycle later, 20-cycle frame
    reqDataA[0*DW +: DW] = 9'h0A5;
    reqValidA = 4'b0001;
    applyStimulus();
    checkOutput("single_ack", reqAckA, 4'b0001);
    checkOutput("single_data", dataA, 9'h0A5);
    checkOutput("single_nostart", startA, 0);
    checkOutput("single_active", activeA, 1);
    reqValidA = '0;
    applyStimulus();
    checkOutput("single_start", startA, 1);
    checkOutput("single_ack_gone", reqAckA, 0);
    applyStimulus();
    checkOutput("single_start_pulse", startA, 0);
    n = 1;
    while (activeA && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("single_len", n, 21);
    checkOutput("single_idle", activeA, 0);
    checkOutput("single_hold", dataA, 9'h0A5);

    // Burst: requester 2 alone, 4 back-to-back frames then a regrant
    busyLenA = 3;
    word = 9'h101;
    reqDataA[2*DW +: DW] = word;
    reqValidA = 4'b0100;
    nAck = 0; t = 0; lastT = 0;
    while (nAck < 9 && t < 200) begin
      applyStimulus();
      t++;
      if (reqAckA != 0) begin
        checkOutput("burst_ack", reqAckA, 4'b0100);
        checkOutput("burst_data", dataA, word);
        if (nAck > 0) checkOutput("burst_gap", t - lastT, (nAck % 4 == 0) ? 6 : 5);
        lastT = t;
        nAck++;
        word = word + 1'b1;
        reqDataA[2*DW +: DW] = word;
        if (nAck == 9) reqValidA = '0;
      end
    end
    checkOutput("burst_count", nAck, 9);
    n = 0;
    while (activeA && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("burst_idle", activeA, 0);

    // Timeout: driver never raises busy
    deadA = 1'b1;
    reqDataA[1*DW +: DW] = 9'h1C3;
    reqValidA = 4'b0010;
    applyStimulus();
    checkOutput("to_ack", reqAckA, 4'b0010);
    checkOutput("to_grant", grantA, 1);
    checkOutput("to_data", dataA, 9'h1C3);
    reqValidA = '0;
    applyStimulus();
    checkOutput("to_start", startA, 1);
    n = 0;
    while (!toErrA && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("to_latency", n, TO);
    checkOutput("to_idle", activeA, 0);
    applyStimulus();
    checkOutput("to_sticky", toErrA, 1);
    errClrA = 1'b1;
    applyStimulus();
    errClrA = 1'b0;
    checkOutput("to_clear", toErrA, 0);
    deadA = 1'b0;

    // Frame error during WAIT_DONE, set-beats-clear, then reset mid-frame
    busyLenA = 10;
    reqDataA[3*DW +: DW] = 9'h0F0;
    reqValidA = 4'b1000;
    applyStimulus();
    checkOutput("fe_ack", reqAckA, 4'b1000);
    checkOutput("fe_grant", grantA, 3);
    reqValidA = '0;
    applyStimulus();
    checkOutput("fe_start", startA, 1);
    repeat (3) applyStimulus();
    errorA = 1'b1; errClrA = 1'b1;
    applyStimulus();
    checkOutput("fe_set_wins", frErrA, 1);
    errorA = 1'b0;
    applyStimulus();
    checkOutput("fe_clear", frErrA, 0);
    errClrA = 1'b0; errorA = 1'b1;
    applyStimulus();
    errorA = 1'b0;
    checkOutput("fe_set", frErrA, 1);
    checkOutput("fe_active", activeA, 1);
    reqDataA[3*DW +: DW] = 9'h0F1;
    reqValidA = 4'b1000;
    rst = 1'b1;
    applyStimulus();
    checkOutput("mid_rst_ack", reqAckA, 0);
    checkOutput("mid_rst_start", startA, 0);
    checkOutput("mid_rst_data", dataA, 0);
    checkOutput("mid_rst_grant", grantA, 0);
    checkOutput("mid_rst_active", activeA, 0);
    checkOutput("mid_rst_frerr", frErrA, 0);
    checkOutput("mid_rst_toerr", toErrA, 0);
    seen = 0;
    repeat (3) begin
      applyStimulus();
      if (reqAckA != 0 || startA) seen++;
    end
    checkOutput("mid_rst_quiet", seen, 0);
    reqValidA = '0;
    rst = 1'b0;
    applyStimulus();

    // Round-robin with single-word grants: 0,1,2,3,0
    for (int i = 0; i < NR; i++) begin
      wordsB[i] = 9'h100 + 9'(i * 16);
      reqDataB[i*DW +: DW] = wordsB[i];
    end
    reqValidB = 4'b1111;
    nAck = 0; t = 0; lastT = 0;
    while (nAck < 5 && t < 300) begin
      applyStimulus();
      t++;
      if (reqAckB != 0) begin
        g = nAck % 4;
        checkOutput("rr_ack", reqAckB, 4'b0001 << g);
        checkOutput("rr_grant", grantB, g);
        checkOutput("rr_data", dataB, wordsB[g]);
        if (nAck > 0) checkOutput("rr_gap", t - lastT, 7);
        lastT = t;
        nAck++;
        wordsB[g] = wordsB[g] + 1'b1;
        reqDataB[g*DW +: DW] = wordsB[g];
      end
    end
    checkOutput("rr_count", nAck, 5);
    reqValidB = '0;
    n = 0;
    while (activeB && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("rr_idle", activeB, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
